// File: rtl/systolic_seq_if.sv
// systolic_seq_if: host command / array control bundle for systolic_seq
// The accum command bit exists only when SYSTOLIC_SEQ_ACCUM_EN is defined.
interface systolic_seq_if #(parameter int DIM = 8, parameter int CNT_W = 8);
  logic start;
  logic [CNT_W-1:0] k_len;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
  logic accum;
`endif
  logic busy;
  logic done;
  logic mac_en;
  logic mac_wr_en;
  logic c_zero;
  logic [DIM-1:0] row_vld;
  logic [DIM-1:0] col_vld;
  logic [CNT_W-1:0] feed_t;
  logic out_vld;
  logic [$clog2(DIM)-1:0] out_row;
  modport master (
`ifdef SYSTOLIC_SEQ_ACCUM_EN
    output accum,
`endif
    output start, k_len,
    input busy, done, mac_en, mac_wr_en, c_zero, row_vld, col_vld, feed_t, out_vld, out_row
  );
  modport slave (
`ifdef SYSTOLIC_SEQ_ACCUM_EN
    input accum,
`endif
    input start, k_len,
    output busy, done, mac_en, mac_wr_en, c_zero, row_vld, col_vld, feed_t, out_vld, out_row
  );
endinterface

// File: rtl/systolic_seq.sv
// systolic_seq: clear/feed/flush/drain sequencer for a DIM x DIM tpumac array.
// Define SYSTOLIC_SEQ_ACCUM_EN to add the accum command that skips CLEAR.
module systolic_seq #(
  parameter int DIM = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  systolic_seq_if.slave bus
);
  localparam int AW = $clog2(DIM);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, FEED = 3'd2, FLUSH = 3'd3, DRAIN = 3'd4, DONE = 3'd5;
  logic [2:0] st, nxt;
  logic [CNT_W-1:0] k_r, feed_t;
  logic [AW-1:0] d_cnt;
  logic [DIM-1:0] rv;
  logic skip, last;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
  assign skip = bus.accum;
`else
  assign skip = 1'b0;
`endif
  assign last = feed_t == k_r + CNT_W'(2 * DIM - 3);
  always_comb begin
    nxt = st == IDLE  ? (bus.start ? (skip ? (bus.k_len == '0 ? DRAIN : FEED) : CLEAR) : IDLE)
        : st == CLEAR ? (k_r == '0 ? DRAIN : FEED)
        : st == FEED  ? (last ? FLUSH : FEED)
        : st == FLUSH ? DRAIN
        : st == DRAIN ? (d_cnt == '0 ? DONE : DRAIN)
        : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      k_r <= '0;
      feed_t <= '0;
      d_cnt <= '0;
    end else begin
      st <= nxt;
      k_r <= (st == IDLE && bus.start) ? bus.k_len : k_r;
      feed_t <= (st == FEED && !last) ? feed_t + 1'b1 : '0;
      d_cnt <= st == DRAIN ? d_cnt - 1'b1 : AW'(DIM - 1);
    end
  end
  // Diagonal skew: lane i carries element feed_t - i while that index lies in 0..k_r-1.
  always_comb begin
    rv = '0;
    for (int i = 0; i < DIM; i++)
      rv[i] = st == FEED && ({1'b0, feed_t} >= (CNT_W + 1)'(i))
              && ({1'b0, feed_t} < (CNT_W + 1)'(i) + {1'b0, k_r});
  end
  assign bus.busy = st != IDLE;
  assign bus.done = st == DONE;
  assign bus.mac_en = st == CLEAR || st == FEED || st == FLUSH || st == DRAIN;
  assign bus.mac_wr_en = st == CLEAR || st == DRAIN;
  assign bus.c_zero = st == CLEAR;
  assign bus.row_vld = rv;
  assign bus.col_vld = rv;
  assign bus.feed_t = feed_t;
  assign bus.out_vld = st == DRAIN;
  assign bus.out_row = st == DRAIN ? d_cnt : '0;
endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: scoreboard bench for systolic_seq with DIM=4, CNT_W=8.
module tb_systolic_seq;
  localparam int D = 4;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [23:0] sb [$];
  systolic_seq_if #(.DIM(D), .CNT_W(CW)) bus ();
  systolic_seq #(.DIM(D), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [23:0] obs();
    return {bus.busy, bus.done, bus.mac_en, bus.mac_wr_en, bus.c_zero, bus.row_vld, bus.col_vld,
            bus.feed_t, bus.out_vld, bus.out_row};
  endfunction
  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask
  // Expected outputs in cycle c after a start at cycle 0, from the phase timeline.
  function automatic logic [23:0] model(input int c, input int k, input bit acc);
    int fs, fl, ds, dn, t;
    bit clr, fd, flu, dr;
    logic [3:0] rv;
    fs = acc ? 1 : 2;
    fl = fs + k + 2 * D - 2;
    ds = k > 0 ? fl + 1 : fs;
    dn = ds + D;
    clr = !acc && c == 1;
    fd = k > 0 && c >= fs && c < fl;
    flu = k > 0 && c == fl;
    dr = c >= ds && c < dn;
    t = c - fs;
    rv = '0;
    for (int r = 0; r < D; r++) rv[r] = fd && t >= r && t < r + k;
    return {c >= 1 && c <= dn, c == dn, clr || fd || flu || dr, clr || dr, clr, rv, rv,
            fd ? 8'(t) : 8'd0, dr, dr ? 2'(D - 1 - (c - ds)) : 2'd0};
  endfunction
  task automatic op(input int k, input bit acc, input int ign_a, input int ign_b, input int rst_at);
    int n;
    logic [23:0] e;
    n = k > 0 ? (acc ? 1 : 2) + k + 3 * D : (acc ? 1 : 2) + D + 2;
    for (int c = 1; c <= n; c++) sb.push_back((rst_at > 0 && c > rst_at) ? 24'd0 : model(c, k, acc));
    start_cmd(k, acc);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.k_len = 8'($urandom);
    for (int c = 1; c <= n; c++) begin
      e = sb.pop_front();
      chk($sformatf("k%0d a%0d r%0d c%0d", k, acc, rst_at, c), obs(), e);
      bus.start = c == ign_a || c == ign_b;
      rst_n = !(c == rst_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic start_cmd(input int k, input bit acc);
    bus.start = 1'b1;
    bus.k_len = 8'(k);
`ifdef SYSTOLIC_SEQ_ACCUM_EN
    bus.accum = acc;
`else
    if (acc) $display("accum requested without SYSTOLIC_SEQ_ACCUM_EN");
`endif
  endtask
  initial begin
    bus.start = 1'b1;
    bus.k_len = 8'd3;
`ifdef SYSTOLIC_SEQ_ACCUM_EN
    bus.accum = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", obs(), 24'd0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("reset_start_dropped", obs(), 24'd0);
    op(3, 1'b0, 0, 0, 0);
    op(3, 1'b0, 5, 16, 0);
    op(0, 1'b0, 0, 0, 0);
    op(3, 1'b0, 0, 0, 5);
    op(1, 1'b0, 0, 0, 0);
    op(6, 1'b0, 3, 0, 14);
    op(5, 1'b0, 0, 0, 0);
`ifdef SYSTOLIC_SEQ_ACCUM_EN
    op(3, 1'b1, 0, 0, 0);
    op(0, 1'b1, 0, 0, 0);
    op(2, 1'b1, 4, 0, 0);
`endif
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_tail", obs(), 24'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_seq.md
# systolic_seq

Sequencer for a DIM×DIM systolic array of tpumac cells. It drives the shared `en`, `WrEn` and Cin-zero controls, and generates the diagonal skew that staggers A rows and B columns into the array edges. After the last partial product it drains the Cout column chain out of the bottom row. It sits between the host command interface and the array plus its A/B edge feeders, and reports completion with a one-cycle `done` pulse.

## Interface
- `DIM`, default 8: array rows and columns; must be ≥ 2.
- `CNT_W`, default 8: width of `k_len` and `feed_t`; `k_len + 2*DIM - 3` must fit in CNT_W bits.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  command strobe; accepted only in IDLE.
- `k_len`  in  CNT_W  inner dimension K; sampled with `start`.
- `accum`  in  1  skip CLEAR and accumulate onto the existing Cout (exists only with the macro; see Configuration).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `mac_en`  out  1  drives `en` of all cells.
- `mac_wr_en`  out  1  drives `WrEn` of all cells.
- `c_zero`  out  1  forces row-0 Cin to 0.
- `row_vld`  out  DIM  bit r: A feeder r presents element `feed_t - r`; otherwise it drives 0.
- `col_vld`  out  DIM  bit c: B feeder c presents element `feed_t - c`; otherwise it drives 0.
- `feed_t`  out  CNT_W  FEED step counter.
- `out_vld`  out  1  bottom-row Cout holds a result row.
- `out_row`  out  $clog2(DIM)  index of that result row.

## Operation
- States are IDLE → CLEAR → FEED → FLUSH → DRAIN → DONE → IDLE.
- IDLE:
  - All outputs are 0.
  - `start`=1 latches `k_len` into `k_r` and moves to CLEAR.
- CLEAR, 1 cycle: `mac_en`=1, `mac_wr_en`=1, `c_zero`=1, which loads 0 into every accumulator.
  - Next state is FEED, or DRAIN if `k_r`==0.
- FEED, `k_r + 2*DIM - 2` cycles:
  - `mac_en`=1 and `mac_wr_en`=0.
  - `feed_t` counts 0, 1, … upward.
  - `row_vld[r]` = (`feed_t` ≥ r) && (`feed_t` < r + `k_r`); `col_vld` uses the same rule per column.
  - On the last count, go to FLUSH.
- FLUSH, 1 cycle: `mac_en`=1 and all vld bits are 0. This lets cell (DIM-1,DIM-1) register its final product.
- DRAIN, DIM cycles:
  - `mac_en`=1, `mac_wr_en`=1, `c_zero`=0, so Cout shifts down one row per cycle.
  - `out_vld`=1; `out_row` runs DIM-1 down to 0, bottom row first.
- DONE, 1 cycle: `done`=1 and `busy`=1, then return to IDLE.
- `start` outside IDLE is ignored, DONE included, so back-to-back commands cost one IDLE cycle.
- `k_len` changes after acceptance have no effect.
- `feed_t` holds 0 outside FEED.
- `out_row` is 0 when `out_vld`=0.
- With `k_r`=0 the path is CLEAR → DRAIN, and the drained rows are all zero.

## Timing
- Cycle 0 is the edge on which `start` is sampled.
- `busy` is 1 from cycle 1 through the DONE cycle.
- CLEAR occupies cycle 1.
- FEED occupies cycles 2 … K+2·DIM-1.
- FLUSH occupies cycle K+2·DIM.
- DRAIN occupies cycles K+2·DIM+1 … K+3·DIM.
- `done` is high in cycle K+3·DIM+1.
- Every output is registered and depends only on state and counters; no input-to-output combinational path exists.
- Reset:
  - `rst_n`=0 at any edge, including mid-FEED or mid-DRAIN, puts the block in IDLE with all outputs 0 on the next cycle.
  - A partial operation is abandoned with no `done`.
  - `start` during reset is dropped.

## Configuration
- `SYSTOLIC_SEQ_ACCUM_EN` defined:
  - The `accum` port exists.
  - If `accum`=1 at start, CLEAR is skipped and IDLE goes straight to FEED (or DRAIN if K=0). All later cycles shift 1 earlier.
- `SYSTOLIC_SEQ_ACCUM_EN` undefined:
  - The port is absent.
  - CLEAR always runs.

## Test plan
DIM=4, CNT_W=8.
- Reset: hold `rst_n`=0 for 2 cycles → every output is 0 and `busy`=0.
- Basic op, K=3, start at cycle 0:
  - `busy` rises at cycle 1; `c_zero`=1 only at cycle 1.
  - FEED runs cycles 2–10. `row_vld` is 0001 at t=0, 0111 at t=2, 1110 at t=3, 1000 at t=5, 0000 at t=6–8.
  - FLUSH at cycle 11. DRAIN at cycles 12–15 with `out_row` 3,2,1,0.
  - `done` at cycle 16.
- Ignored start: pulse `start` at cycles 5 and 16 (DONE) of a K=3 op → no restart; `busy`=0 at cycle 17.
- K=0: CLEAR at cycle 1, DRAIN at cycles 2–5, `done` at cycle 6, no `row_vld` activity.
- Reset mid-op: assert `rst_n`=0 at cycle 5 of a K=3 op → cycle 6 has all outputs 0 and no `done` follows.
- With `SYSTOLIC_SEQ_ACCUM_EN`, `accum`=1, K=3: `c_zero` is never asserted, FEED runs cycles 1–9, `done` at cycle 15.
